// File: rtl/matrix_mult_pkg.sv
// Shared types and arithmetic helpers for the sequential signed matrix multiplier.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    // Widest accumulator over the legal W (<=32) and N (<=8) range.
    localparam int ACC_MAX = 2 * 32 + 3;

    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    // Returns the narrowed value in the low w bits of the result.
    function automatic logic signed [31:0] narrow(input logic signed [ACC_MAX-1:0] acc,
                                                  input int w,
                                                  input logic sat);
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        logic signed [ACC_MAX-1:0] res;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (w - 1)) - one;
        lo     = ~hi;
        res    = acc;
        if (sat) begin
            if (acc > hi) begin
                res = hi;
            end else if (acc < lo) begin
                res = lo;
            end
        end
        return res[31:0];
    endfunction

endpackage

// File: rtl/matrix_mult_seq_mac.sv
// Signed multiply-accumulate with load-instead-of-add control and a registered accumulator.
module mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     clear_load,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_p1
);

    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]    prod_ext_p0;

    always_comb begin
        prod_p0     = (2 * DATA_W)'(a) * (2 * DATA_W)'(b);
        prod_ext_p0 = ACC_W'(prod_p0);
    end

    // p0 -> p1: accumulate into the registered sum
    always_ff @(posedge clk) begin
        if (en) begin
            acc_p1 <= clear_load ? prod_ext_p0 : acc_p1 + prod_ext_p0;
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N signed matrix multiplier: stream in A then B, one MAC per cycle, stream out Y.
module matrix_mult_seq
    import matrix_mult_pkg::*;
#(
    parameter int N   = 3,
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int NN    = N * N;
    localparam int ACC_W = acc_width(W, N);
    localparam int IW    = $clog2(NN);
    localparam int LW    = $clog2(2 * NN);
    localparam int CW    = $clog2(N);

    state_t              state;
    logic [LW-1:0]       ld_cnt;
    logic [CW-1:0]       ci, cj, ck;
    logic [IW-1:0]       oidx;
    logic [IW-1:0]       oidx_next;
    logic                wr_vld_p1;
    logic [IW-1:0]       wr_idx_p1;

    logic signed [W-1:0] a_mem [NN];
    logic signed [W-1:0] b_mem [NN];
    logic signed [W-1:0] y_mem [NN];

    logic                accept;
    logic                last_ld;
    logic                k_last, j_last, i_last;
    logic [IW-1:0]       a_idx, b_idx, y_idx, lda_idx, ldb_idx;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [ACC_MAX-1:0] acc_ext_p1;
    logic signed [W-1:0]       y_nar_p1;

    always_comb begin
        accept     = in_valid && in_ready;
        last_ld    = (ld_cnt == LW'(2 * NN - 1));
        k_last     = (ck == CW'(N - 1));
        j_last     = (cj == CW'(N - 1));
        i_last     = (ci == CW'(N - 1));
        a_idx      = IW'(int'(ci) * N + int'(ck));
        b_idx      = IW'(int'(ck) * N + int'(cj));
        y_idx      = IW'(int'(ci) * N + int'(cj));
        lda_idx    = IW'(ld_cnt);
        ldb_idx    = IW'(ld_cnt - LW'(NN));
        oidx_next  = oidx + IW'(1);
        acc_ext_p1 = ACC_MAX'(acc_p1);
        y_nar_p1   = W'(narrow(acc_ext_p1, W, SAT != 0));
    end

    mac_unit #(
        .DATA_W (W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .en         (state == COMPUTE),
        .clear_load (ck == '0),
        .a          (a_mem[a_idx]),
        .b          (b_mem[b_idx]),
        .acc_p1     (acc_p1)
    );

    // Operand and result storage carry no reset; their contents are don't-care after reset.
    always_ff @(posedge clk) begin
        wr_idx_p1 <= y_idx;
        if (accept) begin
            if (ld_cnt < LW'(NN)) begin
                a_mem[lda_idx] <= in_data;
            end else begin
                b_mem[ldb_idx] <= in_data;
            end
        end
        // p1 -> p2: the finished dot product lands one cycle after its last MAC
        if (wr_vld_p1) begin
            y_mem[wr_idx_p1] <= y_nar_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            ld_cnt    <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            oidx      <= '0;
            wr_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= (state == COMPUTE) && k_last;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (last_ld) begin
                            ld_cnt   <= '0;
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            ld_cnt <= ld_cnt + LW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (k_last) begin
                        ck <= '0;
                        if (j_last) begin
                            cj <= '0;
                            ci <= i_last ? '0 : ci + CW'(1);
                        end else begin
                            cj <= cj + CW'(1);
                        end
                    end else begin
                        ck <= ck + CW'(1);
                    end
                    if (k_last && j_last && i_last) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_data  <= y_mem[0];
                        out_last  <= 1'b0;
                        oidx      <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            oidx      <= '0;
                        end else begin
                            oidx     <= oidx_next;
                            out_data <= y_mem[oidx_next];
                            out_last <= (oidx_next == IW'(NN - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed bench for matrix_mult_seq: wrap and saturate instances driven side by side.
module tb_matrix_mult_seq;

    localparam int N = 3;
    localparam int W = 16;

    typedef logic signed [W-1:0] mat_t [9];

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] in_data = '0;

    logic                in_ready0, out_valid0, out_last0, busy0;
    logic                in_ready1, out_valid1, out_last1, busy1;
    logic signed [W-1:0] out_data0, out_data1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_last = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_mult_seq #(.N(N), .W(W), .SAT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .out_last  (out_last0),
        .busy      (busy0)
    );

    matrix_mult_seq #(.N(N), .W(W), .SAT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .out_last  (out_last1),
        .busy      (busy1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready0", in_ready0, 0);
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_out_data0", out_data0, 0);
        chk("rst_out_last0", out_last0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_in_ready1", in_ready1, 0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_out_data1", out_data1, 0);
        chk("rst_busy1", busy1, 0);
    endtask

    // Called at a negedge; returns at the negedge after the final B beat is accepted.
    task automatic load(input mat_t a, input mat_t b, input bit gaps);
        int g;
        int guard;
        for (int n = 0; n < 18; n++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = (n < 9) ? a[n] : b[n - 9];
            guard = 0;
            while (!in_ready0 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("in_ready_timeout", in_ready0, 1);
            t_last = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit junk);
        int guard;
        guard = 0;
        while (!out_valid0 && guard < 200) begin
            chk("in_ready_low_busy", in_ready0, 0);
            chk("busy_high", busy0, 1);
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", out_valid0, 1);
        chk("first_valid_latency", cyc - t_last, 28);
    endtask

    task automatic drain(input mat_t e0, input mat_t e1, input bit toggle, input int nbeats);
        int   idx;
        int   guard;
        logic rdy;
        idx   = 0;
        guard = 0;
        rdy   = 1'b1;
        while (idx < nbeats && guard < 200) begin
            rdy       = toggle ? ~rdy : 1'b1;
            out_ready = rdy;
            chk("drain_out_valid", out_valid0, 1);
            chk("drain_in_ready_low", in_ready0, 0);
            chk("out_data_wrap", out_data0, e0[idx]);
            chk("out_data_sat", out_data1, e1[idx]);
            chk("out_last", out_last0, (idx == 8));
            @(negedge clk);
            if (rdy) idx++;
            guard++;
        end
        out_ready = 1'b0;
        if (idx < nbeats) chk("drain_timeout", idx, nbeats);
        if (idx == 9) begin
            chk("in_ready_after_last", in_ready0, 1);
            chk("out_valid_after_last", out_valid0, 0);
            chk("busy_after_last", busy0, 0);
        end
    endtask

    initial begin
        mat_t inc, neg, mix, p200, n200;
        mat_t e_inc, e_mix, e_pw, e_ps, e_nw, e_ns;

        for (int i = 0; i < 9; i++) begin
            inc[i]  = 16'(i + 1);
            neg[i]  = 16'(-(i + 1));
            p200[i] = 16'(200);
            n200[i] = 16'(-200);
            e_pw[i] = 16'(-11072);
            e_ps[i] = 16'(32767);
            e_nw[i] = 16'(11072);
            e_ns[i] = 16'(-32768);
        end
        mix   = '{1, -2, -3, -4, 5, -6, -7, -8, 9};
        e_inc = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        e_mix = '{30, 12, -18, 18, 81, -72, -38, -98, 150};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready0, 1);

        load(inc, inc, 1'b0);
        wait_valid(1'b0);
        drain(e_inc, e_inc, 1'b0, 9);

        load(neg, neg, 1'b0);
        wait_valid(1'b1);
        drain(e_inc, e_inc, 1'b0, 9);

        load(mix, mix, 1'b0);
        wait_valid(1'b0);
        drain(e_mix, e_mix, 1'b0, 9);

        load(p200, p200, 1'b0);
        wait_valid(1'b0);
        drain(e_pw, e_ps, 1'b0, 9);

        load(p200, n200, 1'b0);
        wait_valid(1'b0);
        drain(e_nw, e_ns, 1'b0, 9);

        load(inc, inc, 1'b1);
        wait_valid(1'b1);
        drain(e_inc, e_inc, 1'b1, 9);

        // Reset while computing.
        load(mix, mix, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_mid_compute", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_compute_reset", in_ready0, 1);
        load(inc, inc, 1'b0);
        wait_valid(1'b0);
        drain(e_inc, e_inc, 1'b0, 9);

        // Reset part-way through draining.
        load(mix, mix, 1'b0);
        wait_valid(1'b0);
        drain(e_mix, e_mix, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_drain_reset", in_ready0, 1);
        load(inc, inc, 1'b0);
        wait_valid(1'b0);
        drain(e_inc, e_inc, 1'b0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Parametrised, sequential successor to the combinational 3×3 signed matrix multiplier. It computes Y = A·B for signed N×N matrices of W-bit elements using a single time-shared multiply-accumulate unit. Operands arrive over a valid/ready input stream and results leave over a valid/ready output stream. It is intended for designs where N² parallel dot-product trees are too large and where wrap or saturate result handling must be selectable.

## Interface
- `N`, default 3: matrix dimension, legal range 2..8.
- `W`, default 16: signed element width, legal range 4..32.
- `SAT`, default 0: result narrowing mode. 0 = wrap (keep the low W bits). 1 = saturate to the signed W-bit range.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input element present.
- `in_ready`  out  1  block accepts an input element.
- `in_data`  in  W  signed element. Stream order: A row-major (N² beats), then B row-major (N² beats).
- `out_valid`  out  1  result element present.
- `out_ready`  in  1  consumer accepts a result element.
- `out_data`  out  W  signed result Y[i][j], streamed row-major.
- `out_last`  out  1  high with Y[N-1][N-1] only.
- `busy`  out  1  high in COMPUTE and DRAIN.

## Operation
- The FSM has three states: LOAD → COMPUTE → DRAIN → LOAD.
- LOAD
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`. Beats 0..N²-1 write A; beats N²..2N²-1 write B.
  - Gaps in `in_valid` are allowed.
  - Acceptance of beat 2N²-1 moves the FSM to COMPUTE.
- COMPUTE
  - One MAC per cycle, loop order i, j, then k (k innermost).
  - The accumulator loads the product at k=0 and accumulates for k>0.
  - At k=N-1 the narrowed sum is written to result buffer entry [i][j].
  - The state lasts exactly N³ cycles, then moves to DRAIN.
- DRAIN
  - `out_valid`=1. The element at the output index is driven on `out_data`.
  - The index advances on `out_valid`&&`out_ready`.
  - `out_data` and `out_last` stay stable while stalled.
  - Acceptance of the beat with `out_last`=1 moves the FSM to LOAD.
- Arithmetic
  - Products are full 2W bits.
  - The accumulator is ACC_W = 2W + clog2(N) bits, so no internal overflow can occur.
  - Narrowing applies only on the result write. SAT=0 keeps acc[W-1:0]. SAT=1 clamps to [-2^(W-1), 2^(W-1)-1].
- `in_valid` is ignored outside LOAD. `out_ready` is ignored outside DRAIN.
- Reset values:
  - During reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
  - All counters are zeroed and the state is LOAD.
  - Matrix and result buffer contents are don't-care after reset.
- Reset mid-operation, in any state: the current operation is abandoned. Nothing partial is ever emitted after reset.

## Timing
- `in_ready` rises in the first cycle after `rst` deasserts.
- Let cycle t be the cycle that accepts the last B beat:
  - COMPUTE occupies cycles t+1..t+N³.
  - `out_valid` first asserts in cycle t+N³+1.
  - `in_ready` is 0 from t+1 until LOAD is re-entered.
- With `out_ready` held high, DRAIN lasts N² cycles and `in_ready` returns in the cycle after the `out_last` handshake.
- Throughput with no stalls: one matrix product per 2N² + N³ + N² cycles. For N=3 that is 54 cycles.
- Input and output are never active in the same cycle; there is no overlap between products.

## Structure
- Package `matrix_mult_pkg`:
  - FSM state enum (LOAD, COMPUTE, DRAIN).
  - Function `acc_width(W, N)`.
  - Function `narrow(acc, W, SAT)` implementing wrap/saturate.
- Sub-module `mac_unit`:
  - Signed W×W multiply.
  - ACC_W-bit accumulator with a `clear_load` input (load product instead of accumulate).
  - Registered output.
- Storage: three N²×W arrays (A, B, Y), addressed by flattened row-major index.

## Test plan
- N=3, W=16, SAT=0, A=B=[1..9] row-major -> output stream 30,36,42,66,81,96,102,126,150; `out_last` on the 9th beat; first `out_valid` 28 cycles after the last input beat.
- Same configuration, A=B=[-1..-9] -> identical output stream to the previous scenario.
- A=B=[1,-2,-3;-4,5,-6;-7,-8,9] -> 30,12,-18,18,81,-72,-38,-98,150.
- Overflow, A all 200:
  - B all 200: each Y = 120000 -> SAT=0 gives -11072; SAT=1 gives 32767.
  - B all -200: SAT=0 gives 11072; SAT=1 gives -32768.
- Handshake stress:
  - Random `in_valid` gaps and `out_ready` toggling every cycle.
  - Results must match the first scenario; `out_data` is stable across stalls.
  - `in_ready`=0 throughout COMPUTE and DRAIN; inputs offered then are ignored.
- Reset mid-COMPUTE, and separately mid-DRAIN:
  - All outputs equal their reset values in the reset cycle.
  - `in_ready`=1 in the next cycle.
  - A fresh load of the first scenario's operands yields its exact stream; no stale beats appear.
